// File: rtl/ahb_slave_if_if.sv
// Bus bundle between the AHB master side and the bridge front end.
// The master modport also carries PRDATA, which the APB side drives.
interface ahb_slave_if_if;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic        HREADYin;
   logic [31:0] PRDATA;

   logic [31:0] HADDR_1;
   logic [31:0] HADDR_2;
   logic [31:0] HADDR_3;
   logic [31:0] HWDATA_1;
   logic [31:0] HWDATA_2;
   logic [31:0] HWDATA_3;
   logic        HWRITEreg;
   logic [2:0]  HSIZEreg;
   logic        valid;
   logic [2:0]  TEMP_SEL;
   logic [1:0]  HRESP;
   logic        ERR_READY;
   logic [31:0] HRDATA;

   modport master (
      output HADDR, HWDATA, HTRANS, HWRITE, HSIZE, HREADYin, PRDATA,
      input  HADDR_1, HADDR_2, HADDR_3, HWDATA_1, HWDATA_2, HWDATA_3,
             HWRITEreg, HSIZEreg, valid, TEMP_SEL, HRESP, ERR_READY, HRDATA
   );

   modport slave (
      input  HADDR, HWDATA, HTRANS, HWRITE, HSIZE, HREADYin, PRDATA,
      output HADDR_1, HADDR_2, HADDR_3, HWDATA_1, HWDATA_2, HWDATA_3,
             HWRITEreg, HSIZEreg, valid, TEMP_SEL, HRESP, ERR_READY, HRDATA
   );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: 3-deep address/data history,
// transfer qualification, APB slave decode and two-cycle ERROR response.
//
// state   | meaning
// E_IDLE  | normal operation, HRESP=OKAY, ERR_READY=1
// E_RESP1 | first ERROR cycle, HRESP=ERROR, ERR_READY=0 (stalls the master)
// E_RESP2 | second ERROR cycle, HRESP=ERROR, ERR_READY=1; new transfers ignored
module ahb_slave_if #(
   parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
   parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
   parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
   parameter logic [31:0] REGION_SIZE = 32'h0400_0000
) (
   input logic         HCLK,
   input logic         HRESET,
   ahb_slave_if_if.slave bus
);

   typedef enum logic [1:0] {
      E_IDLE  = 2'b00,
      E_RESP1 = 2'b01,
      E_RESP2 = 2'b10
   } err_state_e;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   // 33-bit limit so a region ending at the top of the map cannot wrap to zero.
   function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base);
      logic [32:0] limit;
      limit = {1'b0, base} + {1'b0, REGION_SIZE};
      return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
   endfunction

   function automatic logic [2:0] decode_sel(input logic [31:0] addr);
      logic [2:0] sel;
      sel = 3'b000;
      if (in_region(addr, SLV0_BASE)) sel[0] = 1'b1;
      if (in_region(addr, SLV1_BASE)) sel[1] = 1'b1;
      if (in_region(addr, SLV2_BASE)) sel[2] = 1'b1;
      return sel;
   endfunction

   logic [2:0][31:0] haddr_q,  haddr_d;
   logic [2:0][31:0] hwdata_q, hwdata_d;
   logic             hwrite_q, hwrite_d;
   logic [2:0]       hsize_q,  hsize_d;

   err_state_e err_state_q;
   logic [1:0] hresp_q;
   logic       err_ready_q;

   logic active;
   logic hit;

   assign active = bus.HTRANS[1];
   assign hit    = |decode_sel(bus.HADDR);

   always_comb begin
      haddr_d  = haddr_q;
      hwdata_d = hwdata_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      if (bus.HREADYin) begin
         haddr_d  = {haddr_q[1],  haddr_q[0],  bus.HADDR};
         hwdata_d = {hwdata_q[1], hwdata_q[0], bus.HWDATA};
         hwrite_d = bus.HWRITE;
         hsize_d  = bus.HSIZE;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         haddr_q  <= '0;
         hwdata_q <= '0;
         hwrite_q <= 1'b0;
         hsize_q  <= 3'b000;
      end else begin
         haddr_q  <= haddr_d;
         hwdata_q <= hwdata_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         err_state_q <= E_IDLE;
         hresp_q     <= HRESP_OKAY;
         err_ready_q <= 1'b1;
      end else begin
         case (err_state_q)
            E_IDLE: begin
               if (bus.HREADYin && active && !hit) begin
                  err_state_q <= E_RESP1;
                  hresp_q     <= HRESP_ERROR;
                  err_ready_q <= 1'b0;
               end
            end
            E_RESP1: begin
               err_state_q <= E_RESP2;
               hresp_q     <= HRESP_ERROR;
               err_ready_q <= 1'b1;
            end
            E_RESP2: begin
               err_state_q <= E_IDLE;
               hresp_q     <= HRESP_OKAY;
               err_ready_q <= 1'b1;
            end
            default: begin
               err_state_q <= E_IDLE;
               hresp_q     <= HRESP_OKAY;
               err_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.HADDR_1   = haddr_q[0];
   assign bus.HADDR_2   = haddr_q[1];
   assign bus.HADDR_3   = haddr_q[2];
   assign bus.HWDATA_1  = hwdata_q[0];
   assign bus.HWDATA_2  = hwdata_q[1];
   assign bus.HWDATA_3  = hwdata_q[2];
   assign bus.HWRITEreg = hwrite_q;
   assign bus.HSIZEreg  = hsize_q;
   assign bus.valid     = bus.HREADYin && active && hit && (err_state_q == E_IDLE);
   assign bus.TEMP_SEL  = decode_sel(haddr_q[0]);
   assign bus.HRESP     = hresp_q;
   assign bus.ERR_READY = err_ready_q;
   assign bus.HRDATA    = bus.PRDATA;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Bench for ahb_slave_if: directed vector table followed by random traffic,
// both checked against a behavioural model of the history and error response.
module tb_ahb_slave_if;

   logic HCLK = 1'b0;
   logic HRESET;
   always #5 HCLK = ~HCLK;

   ahb_slave_if_if bus ();

   ahb_slave_if dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: history as arrays, error response as a countdown
   logic [31:0] m_a [3];
   logic [31:0] m_w [3];
   logic        m_wr;
   logic [2:0]  m_sz;
   int          m_err;
   logic        last_valid;

   function automatic logic [2:0] m_sel(input logic [31:0] a);
      longint la;
      la = longint'(a);
      for (int i = 0; i < 3; i++) begin
         longint base;
         base = 64'h8000_0000 + longint'(i) * 64'h0400_0000;
         if (la >= base && la < base + 64'h0400_0000) return 3'(1 << i);
      end
      return 3'b000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_a[i] = '0;
         m_w[i] = '0;
      end
      m_wr  = 1'b0;
      m_sz  = 3'b000;
      m_err = 0;
   endtask

   task automatic cycle(input logic rst, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] trans, input logic wr, input logic [2:0] sz,
                        input logic rdy, input logic [31:0] prd);
      logic mv;
      HRESET       = rst;
      bus.HADDR    = addr;
      bus.HWDATA   = wdata;
      bus.HTRANS   = trans;
      bus.HWRITE   = wr;
      bus.HSIZE    = sz;
      bus.HREADYin = rdy;
      bus.PRDATA   = prd;
      #1;
      mv = rdy && trans[1] && (m_sel(addr) != 3'b000) && (m_err == 0);
      last_valid = bus.valid;
      chk("valid", 32'(bus.valid), 32'(mv));
      chk("HRDATA", bus.HRDATA, prd);
      @(posedge HCLK);
      if (rst) begin
         model_reset();
      end else begin
         if (rdy) begin
            m_a[2] = m_a[1]; m_a[1] = m_a[0]; m_a[0] = addr;
            m_w[2] = m_w[1]; m_w[1] = m_w[0]; m_w[0] = wdata;
            m_wr = wr;
            m_sz = sz;
         end
         if (m_err > 0) m_err--;
         else if (rdy && trans[1] && m_sel(addr) == 3'b000) m_err = 2;
      end
      #1;
      chk("HADDR_1", bus.HADDR_1, m_a[0]);
      chk("HADDR_2", bus.HADDR_2, m_a[1]);
      chk("HADDR_3", bus.HADDR_3, m_a[2]);
      chk("HWDATA_1", bus.HWDATA_1, m_w[0]);
      chk("HWDATA_2", bus.HWDATA_2, m_w[1]);
      chk("HWDATA_3", bus.HWDATA_3, m_w[2]);
      chk("HWRITEreg", 32'(bus.HWRITEreg), 32'(m_wr));
      chk("HSIZEreg", 32'(bus.HSIZEreg), 32'(m_sz));
      chk("TEMP_SEL", 32'(bus.TEMP_SEL), 32'(m_sel(m_a[0])));
      chk("HRESP", 32'(bus.HRESP), (m_err > 0) ? 32'd1 : 32'd0);
      chk("ERR_READY", 32'(bus.ERR_READY), (m_err == 2) ? 32'd0 : 32'd1);
   endtask

   typedef struct {
      logic        rst;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        wr;
      logic        rdy;
      logic        e_valid;
      logic [1:0]  e_resp;
      logic        e_rdy;
      logic [2:0]  e_sel;
      logic [31:0] e_h1;
      logic [31:0] e_h2;
      logic [31:0] e_h3;
   } vec_t;

   vec_t vt [21];

   initial begin
      // reset, writes, stall, error, BUSY, reset in error, region edges
      vt[0]  = '{1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0};
      vt[1]  = '{1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0};
      vt[2]  = '{1'b0, 32'h8000_0010, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 3'b001, 32'h8000_0010, 32'h0, 32'h0};
      vt[3]  = '{1'b0, 32'h8400_0000, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 3'b010, 32'h8400_0000, 32'h8000_0010, 32'h0};
      vt[4]  = '{1'b0, 32'h8400_0004, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 3'b010, 32'h8400_0004, 32'h8400_0000, 32'h8000_0010};
      vt[5]  = '{1'b0, 32'h8400_0008, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 3'b010, 32'h8400_0008, 32'h8400_0004, 32'h8400_0000};
      vt[6]  = '{1'b0, 32'h8800_0000, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 3'b010, 32'h8400_0008, 32'h8400_0004, 32'h8400_0000};
      vt[7]  = '{1'b0, 32'h8800_0004, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 3'b010, 32'h8400_0008, 32'h8400_0004, 32'h8400_0000};
      vt[8]  = '{1'b0, 32'h9000_0000, 2'b10, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 3'b000, 32'h9000_0000, 32'h8400_0008, 32'h8400_0004};
      vt[9]  = '{1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 3'b000, 32'h9000_0000, 32'h8400_0008, 32'h8400_0004};
      vt[10] = '{1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 32'h0, 32'h9000_0000, 32'h8400_0008};
      vt[11] = '{1'b0, 32'h8800_0000, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3'b100, 32'h8800_0000, 32'h0, 32'h9000_0000};
      vt[12] = '{1'b0, 32'h9000_0000, 2'b10, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 3'b000, 32'h9000_0000, 32'h8800_0000, 32'h0};
      vt[13] = '{1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0};
      vt[14] = '{1'b0, 32'h8BFF_FFFC, 2'b11, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 3'b100, 32'h8BFF_FFFC, 32'h0, 32'h0};
      vt[15] = '{1'b0, 32'h8C00_0000, 2'b10, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 3'b000, 32'h8C00_0000, 32'h8BFF_FFFC, 32'h0};
      vt[16] = '{1'b0, 32'h7FFF_FFFC, 2'b10, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 3'b000, 32'h8C00_0000, 32'h8BFF_FFFC, 32'h0};
      vt[17] = '{1'b0, 32'h7FFF_FFFC, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 32'h7FFF_FFFC, 32'h8C00_0000, 32'h8BFF_FFFC};
      vt[18] = '{1'b0, 32'h7FFF_FFFC, 2'b10, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 3'b000, 32'h7FFF_FFFC, 32'h7FFF_FFFC, 32'h8C00_0000};
      vt[19] = '{1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0};
      vt[20] = '{1'b0, 32'h83FF_FFFC, 2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 3'b001, 32'h83FF_FFFC, 32'h0, 32'h0};

      // unchecked power-up reset so the model and DUT start from a known state
      HRESET = 1'b1;
      bus.HADDR = '0; bus.HWDATA = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
      bus.HSIZE = 3'b000; bus.HREADYin = 1'b1; bus.PRDATA = '0;
      @(posedge HCLK);
      #1;
      model_reset();

      for (int i = 0; i < 21; i++) begin
         cycle(vt[i].rst, vt[i].addr, vt[i].addr ^ 32'h5A5A_5A5A, vt[i].trans, vt[i].wr,
               3'b010, vt[i].rdy, 32'hC0DE_0000 + 32'(i));
         chk($sformatf("vec%0d valid", i), 32'(last_valid), 32'(vt[i].e_valid));
         chk($sformatf("vec%0d HRESP", i), 32'(bus.HRESP), 32'(vt[i].e_resp));
         chk($sformatf("vec%0d ERR_READY", i), 32'(bus.ERR_READY), 32'(vt[i].e_rdy));
         chk($sformatf("vec%0d TEMP_SEL", i), 32'(bus.TEMP_SEL), 32'(vt[i].e_sel));
         chk($sformatf("vec%0d HADDR_1", i), bus.HADDR_1, vt[i].e_h1);
         chk($sformatf("vec%0d HADDR_2", i), bus.HADDR_2, vt[i].e_h2);
         chk($sformatf("vec%0d HADDR_3", i), bus.HADDR_3, vt[i].e_h3);
      end

      for (int n = 0; n < 800; n++) begin
         logic [31:0] a;
         int          pick;
         pick = $urandom_range(0, 5);
         case (pick)
            0, 1, 2: a = 32'h8000_0000 + 32'(pick) * 32'h0400_0000 + ($urandom & 32'h03FF_FFFC);
            3:       a = ($urandom_range(0, 1) != 0) ? 32'h8C00_0000 : 32'h8BFF_FFFC;
            4:       a = $urandom;
            default: a = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFC : 32'h8000_0000;
         endcase
         cycle($urandom_range(0, 39) == 0, a, $urandom, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               $urandom_range(0, 3) != 0, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
